// File: rtl/mext_mul_arbiter.sv
// mext_mul_arbiter: shares one multi-cycle multiplier between two valid/ready requesters.
// Round-robin grant, operands held stable while the multiplier works, timeout watchdog.
// Optional 1-entry result cache enabled by defining MEXT_RESULT_CACHE_EN.
module mext_mul_arbiter #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned TW      = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            r0_req_valid,
    output logic            r0_req_ready,
    input  logic [2:0]      r0_op,
    input  logic [XLEN-1:0] r0_a,
    input  logic [XLEN-1:0] r0_b,
    output logic            r0_resp_valid,
    input  logic            r0_resp_ready,
    output logic [XLEN-1:0] r0_res,
    output logic            r0_err,
    input  logic            r1_req_valid,
    output logic            r1_req_ready,
    input  logic [2:0]      r1_op,
    input  logic [XLEN-1:0] r1_a,
    input  logic [XLEN-1:0] r1_b,
    output logic            r1_resp_valid,
    input  logic            r1_resp_ready,
    output logic [XLEN-1:0] r1_res,
    output logic            r1_err,
    output logic [2:0]      mulsel,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    input  logic            ready,
    input  logic [XLEN-1:0] res
);

    typedef enum logic [1:0] {StIdle, StIssue, StBusy, StResp} state_e;

    state_e            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              ptr_q, ptr_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
    logic [TW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   res0_q, res0_d, res1_q, res1_d;
    logic              err0_q, err0_d, err1_q, err1_d;

    logic              any_valid;
    logic              sel;
    logic [2:0]        sel_op;
    logic [XLEN-1:0]   sel_a, sel_b;
    logic              wr_en, wr_err;
    logic [XLEN-1:0]   wr_res;
    logic              hit;
    logic [XLEN-1:0]   hit_res;

    // Round-robin pick: on a tie the port not granted last time wins.
    always_comb begin
        any_valid = r0_req_valid | r1_req_valid;
        if (r0_req_valid && r1_req_valid) begin
            sel = ~ptr_q;
        end else begin
            sel = r1_req_valid;
        end
        sel_op = sel ? r1_op : r0_op;
        sel_a  = sel ? r1_a  : r0_a;
        sel_b  = sel ? r1_b  : r0_b;
    end

`ifdef MEXT_RESULT_CACHE_EN
    logic            cache_vld_q;
    logic [2:0]      cache_op_q;
    logic [XLEN-1:0] cache_a_q, cache_b_q, cache_res_q;
    logic            fill;

    // Only a real multiplier completion fills the entry; timeouts and illegal ops never do.
    assign fill = (state_q == StBusy) && ready;

    // One-entry result cache, refreshed on every successful multiplier completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cache_vld_q <= 1'b0;
            cache_op_q  <= 3'b000;
            cache_a_q   <= '0;
            cache_b_q   <= '0;
            cache_res_q <= '0;
        end else if (fill) begin
            cache_vld_q <= 1'b1;
            cache_op_q  <= op_q;
            cache_a_q   <= a_q;
            cache_b_q   <= b_q;
            cache_res_q <= res;
        end
    end

    assign hit     = cache_vld_q && (sel_op == cache_op_q) && (sel_a == cache_a_q) &&
                     (sel_b == cache_b_q);
    assign hit_res = cache_res_q;
`else
    assign hit     = 1'b0;
    assign hit_res = '0;
`endif

    // Next-state, grant handshake and result write-back.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        ptr_d        = ptr_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        cnt_d        = cnt_q;
        res0_d       = res0_q;
        res1_d       = res1_q;
        err0_d       = err0_q;
        err1_d       = err1_q;
        r0_req_ready = 1'b0;
        r1_req_ready = 1'b0;
        wr_en        = 1'b0;
        wr_err       = 1'b0;
        wr_res       = '0;

        case (state_q)
            StIdle: begin
                if (any_valid) begin
                    if (sel) r1_req_ready = 1'b1;
                    else     r0_req_ready = 1'b1;
                    gnt_d = sel;
                    ptr_d = sel;
                    op_d  = sel_op;
                    a_d   = sel_a;
                    b_d   = sel_b;
                    if (sel_op == 3'b000) begin
                        wr_en   = 1'b1;
                        wr_err  = 1'b1;
                        state_d = StResp;
                    end else if (hit) begin
                        wr_en   = 1'b1;
                        wr_res  = hit_res;
                        state_d = StResp;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                // ready may still reflect the previous operation here, so it is ignored
                cnt_d   = '0;
                state_d = StBusy;
            end
            StBusy: begin
                cnt_d = cnt_q + TW'(1);
                if (ready) begin
                    wr_en   = 1'b1;
                    wr_res  = res;
                    state_d = StResp;
                end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    wr_en   = 1'b1;
                    wr_err  = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (gnt_q ? r1_resp_ready : r0_resp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (wr_en) begin
            if (gnt_d) begin
                res1_d = wr_res;
                err1_d = wr_err;
            end else begin
                res0_d = wr_res;
                err0_d = wr_err;
            end
        end
    end

    // State registers; pointer resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            gnt_q   <= 1'b0;
            ptr_q   <= 1'b1;
            op_q    <= 3'b000;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            res0_q  <= '0;
            res1_q  <= '0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
        end
    end

    assign mulsel        = (state_q == StIssue || state_q == StBusy) ? op_q : 3'b000;
    assign a             = a_q;
    assign b             = b_q;
    assign r0_resp_valid = (state_q == StResp) && !gnt_q;
    assign r1_resp_valid = (state_q == StResp) && gnt_q;
    assign r0_res        = res0_q;
    assign r0_err        = err0_q;
    assign r1_res        = res1_q;
    assign r1_err        = err1_q;

endmodule

// File: tb/tb_mext_mul_arbiter.sv
// Bench for mext_mul_arbiter: behavioural multiplier, response scoreboard, vector table
// and hand-written corner-case sequences.
module tb_mext_mul_arbiter;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            r0_req_valid, r0_req_ready, r0_resp_valid, r0_resp_ready, r0_err;
    logic [2:0]      r0_op;
    logic [XLEN-1:0] r0_a, r0_b, r0_res;
    logic            r1_req_valid, r1_req_ready, r1_resp_valid, r1_resp_ready, r1_err;
    logic [2:0]      r1_op;
    logic [XLEN-1:0] r1_a, r1_b, r1_res;
    logic [2:0]      mulsel;
    logic [XLEN-1:0] a, b, mul_res;
    logic            mul_ready;

    always #5 clk = ~clk;

    mext_mul_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .TW(7)) dut (
        .clk(clk), .rst(rst),
        .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_op(r0_op),
        .r0_a(r0_a), .r0_b(r0_b), .r0_resp_valid(r0_resp_valid),
        .r0_resp_ready(r0_resp_ready), .r0_res(r0_res), .r0_err(r0_err),
        .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_op(r1_op),
        .r1_a(r1_a), .r1_b(r1_b), .r1_resp_valid(r1_resp_valid),
        .r1_resp_ready(r1_resp_ready), .r1_res(r1_res), .r1_err(r1_err),
        .mulsel(mulsel), .a(a), .b(b), .ready(mul_ready), .res(mul_res)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural multiplier: op 001 low product, op 100 unsigned high product, else a mix.
    function automatic logic [31:0] mul_model(logic [2:0] op, logic [31:0] x, logic [31:0] y);
        logic [63:0] p;
        p = {32'd0, x} * {32'd0, y};
        case (op)
            3'b001:  return p[31:0];
            3'b100:  return p[63:32];
            default: return (x ^ y) + {29'd0, op};
        endcase
    endfunction

    bit tie_low = 1'b0;
    int lat_cfg = 1;
    int mcnt;

    // Multiplier busy counter: cycles mulsel has been non-idle.
    always @(posedge clk or negedge rst) begin
        if (!rst) mcnt <= 0;
        else if (mulsel == 3'b000) mcnt <= 0;
        else mcnt <= mcnt + 1;
    end

    assign mul_ready = !tie_low && (mulsel != 3'b000) && (mcnt >= lat_cfg);
    assign mul_res   = mul_ready ? mul_model(mulsel, a, b) : 32'hDEAD_BEEF;

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic bound_fail(string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: cycle bound expired", name);
    endtask

    typedef struct packed {
        logic        port;
        logic [31:0] res;
        logic        err;
    } exp_t;

    exp_t sb_q[$];

    function automatic exp_t make_exp(logic port, logic [2:0] op, logic [31:0] x, logic [31:0] y);
        exp_t e;
        e.port = port;
        e.err  = (op == 3'b000) || tie_low;
        e.res  = e.err ? 32'd0 : mul_model(op, x, y);
        return e;
    endfunction

    task automatic check_resp(logic port, logic [31:0] got_res, logic got_err);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL resp_unexpected: port %0d res %0h with nothing outstanding",
                     port, got_res);
        end else begin
            e = sb_q.pop_front();
            check("resp_port", {63'd0, port}, {63'd0, e.port});
            check("resp_res", {32'd0, got_res}, {32'd0, e.res});
            check("resp_err", {63'd0, got_err}, {63'd0, e.err});
        end
    endtask

    // Scoreboard: push on request handshake, pop and compare on response handshake.
    always @(negedge clk) begin
        if (rst) begin
            if (r0_req_valid && r0_req_ready) sb_q.push_back(make_exp(1'b0, r0_op, r0_a, r0_b));
            if (r1_req_valid && r1_req_ready) sb_q.push_back(make_exp(1'b1, r1_op, r1_a, r1_b));
            if (r0_req_ready || r1_req_ready)
                check("req_ready_excl", {63'd0, r0_req_ready && r1_req_ready}, 64'd0);
            if (r0_resp_valid || r1_resp_valid)
                check("resp_valid_excl", {63'd0, r0_resp_valid && r1_resp_valid}, 64'd0);
            if (r0_resp_valid && r0_resp_ready) check_resp(1'b0, r0_res, r0_err);
            if (r1_resp_valid && r1_resp_ready) check_resp(1'b1, r1_res, r1_err);
        end
    end

    logic       s_hs0, s_hs1, s_rv0, s_rv1, s_rr0, s_rr1;
    logic [2:0] s_mulsel;
    logic [31:0] s_a, s_b;

    // One clock: sample at negedge, then drop any request that was just accepted.
    task automatic step();
        @(negedge clk);
        s_hs0    = r0_req_valid && r0_req_ready;
        s_hs1    = r1_req_valid && r1_req_ready;
        s_rv0    = r0_resp_valid;
        s_rv1    = r1_resp_valid;
        s_rr0    = r0_req_ready;
        s_rr1    = r1_req_ready;
        s_mulsel = mulsel;
        s_a      = a;
        s_b      = b;
        @(posedge clk);
        #1;
        if (s_hs0) r0_req_valid = 1'b0;
        if (s_hs1) r1_req_valid = 1'b0;
    endtask

    task automatic send(logic port, logic [2:0] op, logic [31:0] x, logic [31:0] y);
        if (port) begin
            r1_req_valid = 1'b1; r1_op = op; r1_a = x; r1_b = y;
        end else begin
            r0_req_valid = 1'b1; r0_op = op; r0_a = x; r0_b = y;
        end
    endtask

    function automatic bit idle_all();
        return sb_q.size() == 0 && !r0_req_valid && !r1_req_valid &&
               !r0_resp_valid && !r1_resp_valid;
    endfunction

    task automatic wait_done(string name, int budget);
        int n = 0;
        while (!idle_all() && n < budget) begin
            step();
            n++;
        end
        if (!idle_all()) begin
            bound_fail(name);
            r0_req_valid = 1'b0;
            r1_req_valid = 1'b0;
            sb_q.delete();
        end
    endtask

    // Single request; cyc = cycles from handshake edge to the first resp_valid sample.
    task automatic lat_run(input logic port, input logic [2:0] op, input logic [31:0] x,
                           input logic [31:0] y, output int cyc, output bit saw_op,
                           output bit held, output bit quiet, output logic [2:0] rmul);
        int  n = 0;
        bit  got_hs = 1'b0;
        bit  rv = 1'b0;
        cyc = 0; saw_op = 1'b0; held = 1'b1; quiet = 1'b1; rmul = 3'b111;
        send(port, op, x, y);
        while (!got_hs && n < 20) begin
            step();
            got_hs = port ? s_hs1 : s_hs0;
            n++;
        end
        if (!got_hs) begin
            bound_fail("lat_handshake");
        end else begin
            while (cyc < 200) begin
                step();
                cyc++;
                quiet &= !(port ? s_rv0 : s_rv1) && !(port ? s_rr0 : s_rr1);
                rv = port ? s_rv1 : s_rv0;
                if (rv) begin
                    rmul = s_mulsel;
                    break;
                end
                if (s_mulsel != 3'b000) begin
                    saw_op = 1'b1;
                    held &= (s_mulsel == op) && (s_a == x) && (s_b == y);
                end
            end
            if (!rv) bound_fail("lat_response");
        end
        wait_done("lat_drain", 40);
    endtask

    typedef struct {
        bit          v0, v1;
        logic [2:0]  op0;
        logic [31:0] a0, b0;
        logic [2:0]  op1;
        logic [31:0] a1, b1;
        int          lat;
        int          first;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, first, n;
        bit saw, held, quiet, stable, no_grant;
        logic [2:0] rmul;
        logic [31:0] hold_res;
        logic hold_err;

        // Ties after reset alternate r0, r1, r0, r1; pointer state carries across rows.
        tbl[0] = '{1, 1, 3'b001, 32'd7, 32'd9, 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0};
        tbl[1] = '{1, 1, 3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 3'b011, 32'd5, 32'd6, 2, 0};
        tbl[2] = '{1, 0, 3'b010, 32'h8000_0000, 32'h8000_0000, 3'b000, 32'd0, 32'd0, 0, 0};
        tbl[3] = '{1, 1, 3'b001, 32'd3, 32'd3, 3'b000, 32'd1, 32'd2, 4, 1};
        tbl[4] = '{0, 1, 3'b000, 32'd0, 32'd0, 3'b101, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1, 1};
        tbl[5] = '{1, 1, 3'b110, 32'd0, 32'hFFFF_FFFF, 3'b111, 32'd1, 32'd2, 6, 0};

        rst = 1'b0;
        r0_req_valid = 1'b0; r0_op = 3'b000; r0_a = '0; r0_b = '0; r0_resp_ready = 1'b1;
        r1_req_valid = 1'b0; r1_op = 3'b000; r1_a = '0; r1_b = '0; r1_resp_ready = 1'b1;
        #12;
        check("rst_mulsel", {61'd0, mulsel}, 64'd0);
        check("rst_a_b", {a, b}, 64'd0);
        check("rst_resp_valid", {62'd0, r0_resp_valid, r1_resp_valid}, 64'd0);
        check("rst_res", {r0_res, r1_res}, 64'd0);
        check("rst_err", {62'd0, r0_err, r1_err}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            lat_cfg = tbl[i].lat;
            if (tbl[i].v0) send(1'b0, tbl[i].op0, tbl[i].a0, tbl[i].b0);
            if (tbl[i].v1) send(1'b1, tbl[i].op1, tbl[i].a1, tbl[i].b1);
            first = -1;
            n = 0;
            do begin
                step();
                if (first < 0 && s_hs0) first = 0;
                else if (first < 0 && s_hs1) first = 1;
                n++;
            end while (!idle_all() && n < 400);
            if (!idle_all()) begin
                bound_fail($sformatf("vec%0d_drain", i));
                r0_req_valid = 1'b0; r1_req_valid = 1'b0; sb_q.delete();
            end else begin
                check($sformatf("vec%0d_first_grant", i), 64'(first), 64'(tbl[i].first));
            end
        end

        // Single request: ISSUE plus three BUSY cycles, then RESP.
        lat_cfg = 3;
        lat_run(1'b0, 3'b001, 32'hFFFF_FFFC, 32'd2, cyc, saw, held, quiet, rmul);
        check("single_latency", 64'(cyc), 64'd5);
        check("single_mulsel_seen", {63'd0, saw}, 64'd1);
        check("single_operands_held", {63'd0, held}, 64'd1);
        check("single_r1_quiet", {63'd0, quiet}, 64'd1);
        check("single_res", {32'd0, r0_res}, 64'hFFFF_FFF8);
        check("single_err", {63'd0, r0_err}, 64'd0);

        // Fastest multiplier: ISSUE plus one BUSY cycle.
        lat_cfg = 1;
        lat_run(1'b1, 3'b100, 32'h1234_5678, 32'h10, cyc, saw, held, quiet, rmul);
        check("min_latency", 64'(cyc), 64'd3);

        // Illegal op goes straight to RESP without touching the multiplier.
        lat_run(1'b0, 3'b000, 32'd5, 32'd6, cyc, saw, held, quiet, rmul);
        check("illegal_latency", 64'(cyc), 64'd1);
        check("illegal_mulsel_idle", {63'd0, saw}, 64'd0);
        check("illegal_res_err", {31'd0, r0_res, r0_err}, 64'd1);

        // Backpressure on r1 while r0 waits.
        lat_cfg = 2;
        r1_resp_ready = 1'b0;
        send(1'b1, 3'b001, 32'd11, 32'd13);
        n = 0;
        do begin
            step();
            n++;
        end while (!s_rv1 && n < 50);
        if (!s_rv1) bound_fail("bp_resp_valid");
        hold_res = r1_res;
        hold_err = r1_err;
        send(1'b0, 3'b001, 32'd2, 32'd21);
        stable = 1'b1;
        no_grant = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            stable &= (r1_res == hold_res) && (r1_err == hold_err) && s_rv1;
            no_grant &= !s_rr0 && (s_mulsel == 3'b000);
        end
        check("bp_hold_stable", {63'd0, stable}, 64'd1);
        check("bp_no_grant", {63'd0, no_grant}, 64'd1);
        check("bp_res", {32'd0, hold_res}, 64'd143);
        r1_resp_ready = 1'b1;
        step();
        check("bp_release_no_grant", {63'd0, s_rr0}, 64'd0);
        step();
        check("bp_r0_granted_next", {63'd0, s_hs0}, 64'd1);
        wait_done("bp_drain", 50);

        // Timeout: ISSUE plus TIMEOUT BUSY cycles, then an error response.
        tie_low = 1'b1;
        lat_run(1'b0, 3'b001, 32'd3, 32'd4, cyc, saw, held, quiet, rmul);
        check("timeout_latency", 64'(cyc), 64'(TIMEOUT + 2));
        check("timeout_mulsel_in_resp", {61'd0, rmul}, 64'd0);
        check("timeout_res_err", {31'd0, r0_res, r0_err}, 64'd1);
        tie_low = 1'b0;
        lat_cfg = 2;
        lat_run(1'b0, 3'b001, 32'd3, 32'd4, cyc, saw, held, quiet, rmul);
        check("after_timeout_latency", 64'(cyc), 64'd4);
        check("after_timeout_res", {32'd0, r0_res}, 64'd12);

        // Reset in the middle of BUSY discards the operation.
        tie_low = 1'b1;
        send(1'b0, 3'b001, 32'h77, 32'h88);
        n = 0;
        do begin
            step();
            n++;
        end while (!s_hs0 && n < 20);
        repeat (4) step();
        check("rst_pre_busy_mulsel", {61'd0, mulsel}, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_mulsel", {61'd0, mulsel}, 64'd0);
        check("rst_mid_a_b", {a, b}, 64'd0);
        check("rst_mid_ready_valid",
              {60'd0, r0_req_ready, r1_req_ready, r0_resp_valid, r1_resp_valid}, 64'd0);
        check("rst_mid_res", {r0_res, r1_res}, 64'd0);
        check("rst_mid_err", {62'd0, r0_err, r1_err}, 64'd0);
        sb_q.delete();
        tie_low = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        quiet = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            quiet &= !s_rv0 && !s_rv1 && (s_mulsel == 3'b000);
        end
        check("rst_mid_no_response", {63'd0, quiet}, 64'd1);

`ifdef MEXT_RESULT_CACHE_EN
        lat_cfg = 2;
        lat_run(1'b0, 3'b001, 32'hFFFC_2F70, 32'd280000, cyc, saw, held, quiet, rmul);
        check("cache_fill_latency", 64'(cyc), 64'd4);
        check("cache_fill_mulsel", {63'd0, saw}, 64'd1);
        lat_run(1'b0, 3'b001, 32'hFFFC_2F70, 32'd280000, cyc, saw, held, quiet, rmul);
        check("cache_hit_latency", 64'(cyc), 64'd1);
        check("cache_hit_mulsel_idle", {63'd0, saw}, 64'd0);
        check("cache_hit_res", {31'd0, r0_res, r0_err}, {31'd0, 32'hB3AC_C400, 1'b0});
        lat_run(1'b0, 3'b001, 32'hFFFC_2F71, 32'd280000, cyc, saw, held, quiet, rmul);
        check("cache_miss_latency", 64'(cyc), 64'd4);
        check("cache_miss_mulsel", {63'd0, saw}, 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
